// File: rtl/ddr2_rw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_rw_scheduler
// Brief    : Round-robin write/read burst sequencer for the DDR2 address path.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_rw_scheduler #(
    parameter int WRITE_BURST  = 8,
    parameter int DEPTH_BURSTS = 4096,
    parameter int CNT_WIDTH    = 13
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 phy_init_done,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 af_afull,
    input  logic                 wdf_afull,
    output logic                 wr_addr_en,
    output logic                 rd_addr_en,
    output logic                 wdf_wren,
    output logic                 wdf_first,
    output logic                 wr_ack,
    output logic                 rd_ack,
    output logic [CNT_WIDTH-1:0] fill_count,
    output logic                 full,
    output logic                 empty,
    output logic                 busy
);

    localparam int WDF_BEATS = WRITE_BURST / 2;
    localparam int BEAT_W    = $clog2(WDF_BEATS);
    localparam logic [BEAT_W-1:0]    c_LAST_BEAT = BEAT_W'(WDF_BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] c_DEPTH     = CNT_WIDTH'(DEPTH_BURSTS);
    localparam logic [CNT_WIDTH-1:0] c_ONE       = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WR_BEAT = 3'd2,
        S_RD_CMD  = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_last_grant_wr;

    logic                w_wr_elig;
    logic                w_rd_elig;
    logic                w_grant_wr;
    logic                w_grant_rd;
    logic [CNT_WIDTH-1:0] w_fill_inc;
    logic [CNT_WIDTH-1:0] w_fill_dec;

    assign w_wr_elig  = wr_req & ~full & ~af_afull & ~wdf_afull;
    assign w_rd_elig  = rd_req & ~empty & ~af_afull;
    // On contention the side that did not win last time gets the slot.
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~r_last_grant_wr);
    assign w_grant_rd = w_rd_elig & (~w_wr_elig |  r_last_grant_wr);
    assign w_fill_inc = fill_count + c_ONE;
    assign w_fill_dec = fill_count - c_ONE;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state         <= S_INIT;
            r_beat          <= '0;
            r_last_grant_wr <= 1'b0;
            wr_addr_en      <= 1'b0;
            rd_addr_en      <= 1'b0;
            wdf_wren        <= 1'b0;
            wdf_first       <= 1'b0;
            wr_ack          <= 1'b0;
            rd_ack          <= 1'b0;
            fill_count      <= '0;
            full            <= 1'b0;
            empty           <= 1'b1;
            busy            <= 1'b0;
        end else begin
            wr_addr_en <= 1'b0;
            rd_addr_en <= 1'b0;
            wdf_wren   <= 1'b0;
            wdf_first  <= 1'b0;
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            busy       <= 1'b1;
            case (r_state)
                S_INIT: begin
                    if (phy_init_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (!phy_init_done) begin
                        r_state <= S_INIT;
                    end else if (w_grant_wr) begin
                        r_state         <= S_WR_BEAT;
                        r_beat          <= '0;
                        r_last_grant_wr <= 1'b1;
                        wdf_wren        <= 1'b1;
                        wdf_first       <= 1'b1;
                        wr_addr_en      <= 1'b1;
                        wr_ack          <= 1'b1;
                        fill_count      <= w_fill_inc;
                        full            <= (w_fill_inc == c_DEPTH);
                        empty           <= 1'b0;
                    end else if (w_grant_rd) begin
                        r_state         <= S_RD_CMD;
                        r_last_grant_wr <= 1'b0;
                        rd_addr_en      <= 1'b1;
                        rd_ack          <= 1'b1;
                        fill_count      <= w_fill_dec;
                        full            <= 1'b0;
                        empty           <= (w_fill_dec == '0);
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_WR_BEAT: begin
                    // Burst always runs to completion; wdf_afull is not re-sampled here.
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= S_GAP;
                        r_beat  <= '0;
                    end else begin
                        r_beat   <= r_beat + BEAT_W'(1);
                        wdf_wren <= 1'b1;
                    end
                end
                S_RD_CMD: begin
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (phy_init_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_INIT;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_rw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_rw_scheduler
// Brief    : Directed plus randomized bench with a queue-based command model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr2_rw_scheduler;

    localparam int WB    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int WDF   = WB / 2;

    // Strobe bundle order: {wdf_wren, wdf_first, wr_addr_en, rd_addr_en, wr_ack, rd_ack}
    localparam logic [5:0] c_WR_FIRST = 6'b111010;
    localparam logic [5:0] c_WR_BEAT  = 6'b100000;
    localparam logic [5:0] c_RD       = 6'b000101;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          phy_init_done = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          af_afull = 1'b0;
    logic          wdf_afull = 1'b0;
    logic          wr_addr_en, rd_addr_en, wdf_wren, wdf_first, wr_ack, rd_ack;
    logic [CW-1:0] fill_count;
    logic          full, empty, busy;

    ddr2_rw_scheduler #(
        .WRITE_BURST  (WB),
        .DEPTH_BURSTS (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .phy_init_done (phy_init_done),
        .wr_req        (wr_req),
        .rd_req        (rd_req),
        .af_afull      (af_afull),
        .wdf_afull     (wdf_afull),
        .wr_addr_en    (wr_addr_en),
        .rd_addr_en    (rd_addr_en),
        .wdf_wren      (wdf_wren),
        .wdf_first     (wdf_first),
        .wr_ack        (wr_ack),
        .rd_ack        (rd_ack),
        .fill_count    (fill_count),
        .full          (full),
        .empty         (empty),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: mode 0 = waiting for calibration, 1 = ready to arbitrate,
    // 2 = committed to a command whose remaining cycles sit in m_q.
    int         m_mode = 0;
    int         m_fill = 0;
    bit         m_last_wr = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_we, m_re;
    logic [5:0] m_out = '0;
    logic [5:0] m_q[$];

    always @(posedge sys_clk) begin
        if (reset) begin
            m_mode    = 0;
            m_fill    = 0;
            m_last_wr = 1'b0;
            m_out     = '0;
            m_busy    = 1'b0;
            m_valid   = 1'b1;
            m_q.delete();
        end else begin
            m_out = '0;
            case (m_mode)
                0: if (phy_init_done) m_mode = 1;
                1: begin
                    if (!phy_init_done) begin
                        m_mode = 0;
                    end else begin
                        m_we = wr_req && (m_fill < DEPTH) && !af_afull && !wdf_afull;
                        m_re = rd_req && (m_fill > 0) && !af_afull;
                        if (m_we && (!m_re || !m_last_wr)) begin
                            m_out = c_WR_FIRST;
                            for (int b = 1; b < WDF; b++) m_q.push_back(c_WR_BEAT);
                            m_q.push_back(6'b0);
                            m_fill++;
                            m_last_wr = 1'b1;
                            m_mode = 2;
                        end else if (m_re) begin
                            m_out = c_RD;
                            m_q.push_back(6'b0);
                            m_fill--;
                            m_last_wr = 1'b0;
                            m_mode = 2;
                        end
                    end
                end
                default: begin
                    if (m_q.size() > 0) m_out = m_q.pop_front();
                    else m_mode = phy_init_done ? 1 : 0;
                end
            endcase
            m_busy = (m_mode != 1);
        end
    end

    always @(posedge sys_clk) begin
        #1;
        if (m_valid) begin
            check("strobes", 32'({wdf_wren, wdf_first, wr_addr_en, rd_addr_en, wr_ack, rd_ack}), 32'(m_out));
            check("fill_count", 32'(fill_count), 32'(m_fill));
            check("full", 32'(full), 32'(m_fill == DEPTH));
            check("empty", 32'(empty), 32'(m_fill == 0));
            check("busy", 32'(busy), 32'(m_busy));
        end
    end

    int n_wren = 0;
    int n_wa = 0;
    int n_ra = 0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
        n_wren += int'(wdf_wren);
        n_wa   += int'(wr_addr_en);
        n_ra   += int'(rd_addr_en);
    endtask

    task automatic wait_wa(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wr_addr_en && n < bound);
        if (!wr_addr_en) check("timeout_wr_addr_en", 32'd0, 32'd1);
    endtask

    task automatic wait_ra(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_addr_en && n < bound);
        if (!rd_addr_en) check("timeout_rd_addr_en", 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int grants;
        int ng;
        int guard;

        repeat (3) tick();
        check("reset_fill", 32'(fill_count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // Calibration not done: requests must be ignored.
        reset  = 1'b0;
        wr_req = 1'b1;
        n_wren = 0;
        repeat (50) tick();
        check("init_no_wren", 32'(n_wren), 32'd0);

        phy_init_done = 1'b1;
        wait_wa(20, n);
        check("first_wa_latency", 32'(n), 32'd2);
        wait_wa(20, n);
        check("burst_period_1", 32'(n), 32'd6);
        wait_wa(20, n);
        check("burst_period_2", 32'(n), 32'd6);
        wr_req = 1'b0;
        repeat (8) tick();
        check("three_burst_wren", 32'(n_wren), 32'd12);
        check("three_burst_fill", 32'(fill_count), 32'd3);

        rd_req = 1'b1;
        wait_ra(20, n);
        rd_req = 1'b0;
        repeat (4) tick();
        check("after_read_fill", 32'(fill_count), 32'd2);

        // Both held: expect W,R,W,R encoded as 1,0,1,0.
        wr_req = 1'b1;
        rd_req = 1'b1;
        grants = 0;
        ng     = 0;
        guard  = 0;
        while (ng < 4 && guard < 60) begin
            tick();
            guard++;
            if (wr_addr_en) begin grants = (grants << 1) | 1; ng++; end
            if (rd_addr_en) begin grants = (grants << 1);     ng++; end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        check("alternation", 32'(grants), 32'b1010);
        repeat (4) tick();
        check("alternation_fill", 32'(fill_count), 32'd2);

        wr_req = 1'b1;
        n_wa   = 0;
        repeat (40) tick();
        check("full_wa_count", 32'(n_wa), 32'd2);
        check("full_flag", 32'(full), 32'd1);
        rd_req = 1'b1;
        wait_ra(20, n);
        wait_wa(20, n);
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (6) tick();
        check("refill_fill", 32'(fill_count), 32'd4);

        rd_req = 1'b1;
        repeat (30) tick();
        check("drain_empty", 32'(empty), 32'd1);
        n_ra = 0;
        repeat (30) tick();
        check("empty_no_read", 32'(n_ra), 32'd0);

        af_afull = 1'b1;
        wr_req   = 1'b1;
        n_wa     = 0;
        n_ra     = 0;
        repeat (30) tick();
        check("afull_no_cmd", 32'(n_wa + n_ra), 32'd0);
        af_afull = 1'b0;
        wait_wa(10, n);
        check("afull_release_latency", 32'(n), 32'd1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 600; i++) begin
            wr_req        = 1'($urandom_range(0, 1));
            rd_req        = 1'($urandom_range(0, 1));
            af_afull      = ($urandom_range(0, 7) == 0);
            wdf_afull     = ($urandom_range(0, 7) == 0);
            phy_init_done = ($urandom_range(0, 31) != 0);
            reset         = ($urandom_range(0, 149) == 0);
            tick();
        end

        // Reset during beat 2 of a write burst.
        reset         = 1'b1;
        phy_init_done = 1'b1;
        af_afull      = 1'b0;
        wdf_afull     = 1'b0;
        rd_req        = 1'b0;
        wr_req        = 1'b1;
        tick();
        reset = 1'b0;
        wait_wa(20, n);
        check("post_reset_wa_latency", 32'(n), 32'd2);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midburst_reset_wren", 32'(wdf_wren), 32'd0);
        check("midburst_reset_fill", 32'(fill_count), 32'd0);
        check("midburst_reset_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        wr_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
